// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_pkg
//  Brief    : Shared state encodings and baud-rate constants for the UART
//             transmit arbiter and its round-robin picker.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

  // Clock cycles per serial bit at a 12 MHz system clock; these mirror the
  // values the rx/tx blocks take from the baud-rate header.
  localparam int unsigned c_B115200 = 104;
  localparam int unsigned c_B57600  = 208;
  localparam int unsigned c_B38400  = 313;
  localparam int unsigned c_B19200  = 625;
  localparam int unsigned c_B9600   = 1250;

  // Arbiter state encodings. GAP is only reachable when the inter-character
  // gap feature is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_e;

  // Index width for N requesters, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_rr_select
//  Brief    : Combinational rotating-priority picker. Scans req starting at
//             ptr, wrapping from N-1 back to 0, and returns the first hit.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter_rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          valid_o,
  output logic [PW-1:0] sel_o
);

  // Walk offsets from highest to lowest so the smallest offset from ptr wins.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    valid_o = 1'b0;
    sel_o   = '0;
    sum     = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (req_i[idx]) begin
        valid_o = 1'b1;
        sel_o   = idx;
      end
    end
  end

endmodule : uart_tx_arbiter_rr_select
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Shares one uart_tx between N byte requesters with round-robin
//             arbitration. One byte is granted per character frame; the
//             arbiter follows tx_ready low then high before re-arbitrating.
//  Options  : UART_TX_ARBITER_GAP_EN - adds a GAP state that idles the line
//             for GAP_BITS*BAUDRATE cycles after each character.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int BAUDRATE = c_B115200,
  parameter int GAP_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N-1:0]           req,
  input  logic [8*N-1:0]         req_data,
  output logic [N-1:0]           ack,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   owner
);

  localparam int PW = $clog2(N);

  // Elaboration-time sanity checks on the configuration.
  if ((N < 2) || (N > 8)) begin : g_bad_n
    $error("uart_tx_arbiter: N must be in 2..8");
  end
  if ((GAP_BITS * BAUDRATE) < 1) begin : g_bad_gap
    $error("uart_tx_arbiter: GAP_BITS*BAUDRATE must be positive");
  end

  arb_state_e    state_q;
  logic [N-1:0]  ack_q;
  logic [7:0]    tx_data_q;
  logic          tx_start_q;
  logic [PW-1:0] owner_q;
  logic [PW-1:0] ptr_q;

  logic          rr_valid;
  logic [PW-1:0] rr_sel;
  logic [PW-1:0] ptr_d;
  logic [N-1:0]  ack_d;
  logic [7:0]    sel_data;

`ifdef UART_TX_ARBITER_GAP_EN
  localparam int GAP_CYCLES = GAP_BITS * BAUDRATE;
  localparam int GW         = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] gap_cnt_q;
`endif

  uart_tx_arbiter_rr_select #(
    .N  (N),
    .PW (PW)
  ) u_rr_select (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (rr_valid),
    .sel_o   (rr_sel)
  );

  // Grant side-effects: next pointer, one-hot ack and the selected byte.
  assign ptr_d    = (rr_sel == PW'(N - 1)) ? '0 : rr_sel + 1'b1;
  assign ack_d    = N'(1) << rr_sel;
  assign sel_data = req_data[{rr_sel, 3'b000} +: 8];

  // Arbitration FSM; all outputs except busy are registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ack_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      owner_q    <= '0;
      ptr_q      <= '0;
`ifdef UART_TX_ARBITER_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      case (state_q)
        ST_IDLE: begin
          if (tx_ready && rr_valid) begin
            tx_start_q <= 1'b1;
            ack_q      <= ack_d;
            tx_data_q  <= sel_data;
            owner_q    <= rr_sel;
            ptr_q      <= ptr_d;
            state_q    <= ST_WAIT_BUSY;
          end
        end
        // Wait for the transmitter to acknowledge the start by dropping ready.
        ST_WAIT_BUSY: begin
          if (!tx_ready) begin
            state_q <= ST_WAIT_DONE;
          end
        end
        // Wait for the frame to finish.
        ST_WAIT_DONE: begin
          if (tx_ready) begin
`ifdef UART_TX_ARBITER_GAP_EN
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
`else
            state_q   <= ST_IDLE;
`endif
          end
        end
`ifdef UART_TX_ARBITER_GAP_EN
        // Hold the line idle for the configured number of bit-times.
        ST_GAP: begin
          if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign owner    = owner_q;
  assign busy     = (state_q != ST_IDLE);

endmodule : uart_tx_arbiter
`default_nettype wire
